uart_rx_fsm: RTL and testbench

//  UART receiver, the far end of the line driven by the team's UART transmit FSM.

---
 rtl/uart_rx_fsm.sv | 267 ++++++++++++++++++++++++++
 tb/tb_uart_rx_fsm.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fsm.sv
// -----------------------------------------------------------------------------
// uart_rx_fsm
//   UART receiver that pairs with the team's UART transmit FSM. It oversamples
//   the asynchronous rx line and rebuilds each frame: start bit, 5-8 data bits
//   LSB-first, optional even parity, and 1 or 2 stop bits. Each received byte
//   is presented on a valid/ready output together with per-frame error flags.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per bit period (>= 4, even)
//
// Ports
//   clk          in   clock
//   arst_n       in   asynchronous active-low reset
//   rx           in   serial line, asynchronous, idle high
//   num_data     in   data bits = 5 + num_data
//   parity       in   1 = an even parity bit follows the data
//   stop_2       in   1 = two stop bits
//   data         out  received byte, zero-extended above the top data bit
//   valid        out  data/flags hold a frame that has not been accepted
//   ready        in   consumer accepts when valid && ready
//   parity_err   out  parity mismatch in the held frame
//   frame_err    out  a stop bit sampled 0 in the held frame
//   overrun_err  out  a frame was dropped while valid && !ready
//
// Build option
//   UART_RX_GLITCH_FILTER_EN: every bit decision is a 2-of-3 majority of the
//   synchronised line around the sample point, taking effect one clk later.
// -----------------------------------------------------------------------------
module uart_rx_fsm #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       rx,
  input  logic [1:0] num_data,
  input  logic       parity,
  input  logic       stop_2,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
`ifdef UART_RX_GLITCH_FILTER_EN
  // The vote needs the sample after the nominal point, so the start decision
  // lands one clk later; every later bit keeps the full-period spacing.
  localparam logic [CW-1:0] START_PT = CW'(CLKS_PER_BIT / 2);
`else
  localparam logic [CW-1:0] START_PT = CW'(CLKS_PER_BIT / 2 - 1);
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP_1, STOP_2} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [1:0]      nd_q, nd_d;
  logic            par_q, par_d;
  logic            st2_q, st2_d;
  logic            armed_q, armed_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;
  logic            done_q, done_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            parity_err_q, parity_err_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_err_q, overrun_err_d;

  logic            sync1_q, rxs_q;
  logic            bit_val;
  logic            sample_tick;
  logic [2:0]      last_bit;

  // Two-flop synchroniser; resets to the idle line level so no start is seen.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rx;
      rxs_q   <= sync1_q;
    end
  end

`ifdef UART_RX_GLITCH_FILTER_EN
  logic rxs_d1_q, rxs_d2_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rxs_d1_q <= 1'b1;
      rxs_d2_q <= 1'b1;
    end else begin
      rxs_d1_q <= rxs_q;
      rxs_d2_q <= rxs_d1_q;
    end
  end

  // rxs_q, rxs_d1_q, rxs_d2_q are the line at point +1, 0 and -1.
  assign bit_val = (rxs_q & rxs_d1_q) | (rxs_q & rxs_d2_q) | (rxs_d1_q & rxs_d2_q);
`else
  assign bit_val = rxs_q;
`endif

  assign sample_tick = (state_q == START) ? (clk_cnt_q == START_PT)
                                          : (clk_cnt_q == BIT_LAST);
  assign last_bit    = 3'd4 + {1'b0, nd_q};

  // Frame FSM: next state, bit timing and per-frame accumulation.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    nd_d      = nd_q;
    par_d     = par_q;
    st2_d     = st2_q;
    armed_d   = armed_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    done_d    = 1'b0;

    if (state_q != IDLE) begin
      clk_cnt_d = sample_tick ? '0 : clk_cnt_q + CW'(1);
    end

    unique case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        if (rxs_q) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d   = START;
          nd_d      = num_data;
          par_d     = parity;
          st2_d     = stop_2;
          shreg_d   = '0;
          bit_cnt_d = '0;
          perr_d    = 1'b0;
          ferr_d    = 1'b0;
        end
      end
      START: begin
        if (sample_tick) begin
          if (bit_val) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
      end
      DATA: begin
        if (sample_tick) begin
          // Shift in from the top; the byte is right-aligned on output.
          shreg_d = {bit_val, shreg_q[7:1]};
          if (bit_cnt_q == last_bit) begin
            state_d = par_q ? PARITY : STOP_1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (sample_tick) begin
          // Unused upper shreg bits are zero, so this is the data-bit parity.
          perr_d  = bit_val != ^shreg_q;
          state_d = STOP_1;
        end
      end
      STOP_1, STOP_2: begin
        if (sample_tick) begin
          ferr_d = ferr_q | ~bit_val;
          if (state_q == STOP_1 && st2_q) begin
            state_d = STOP_2;
          end else begin
            // Return to IDLE at mid-stop so a back-to-back start is caught;
            // after a low stop the line must go high again before re-arming.
            state_d = IDLE;
            done_d  = 1'b1;
            armed_d = ~ferr_d;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output holding register with valid/ready handshake.
  always_comb begin
    data_d        = data_q;
    valid_d       = valid_q;
    parity_err_d  = parity_err_q;
    frame_err_d   = frame_err_q;
    overrun_err_d = overrun_err_q;

    if (valid_q && ready) begin
      valid_d       = 1'b0;
      overrun_err_d = 1'b0;
    end

    if (done_q) begin
      if (!valid_q || ready) begin
        data_d       = shreg_q >> (2'd3 - nd_q);
        parity_err_d = perr_q;
        frame_err_d  = ferr_q;
        valid_d      = 1'b1;
      end else begin
        overrun_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q       <= IDLE;
      clk_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      shreg_q       <= '0;
      nd_q          <= '0;
      par_q         <= 1'b0;
      st2_q         <= 1'b0;
      armed_q       <= 1'b1;
      perr_q        <= 1'b0;
      ferr_q        <= 1'b0;
      done_q        <= 1'b0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop update from the values
      // before the edge, independent of statement order.
      state_q       <= state_d;
      clk_cnt_q     <= clk_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shreg_q       <= shreg_d;
      nd_q          <= nd_d;
      par_q         <= par_d;
      st2_q         <= st2_d;
      armed_q       <= armed_d;
      perr_q        <= perr_d;
      ferr_q        <= ferr_d;
      done_q        <= done_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      parity_err_q  <= parity_err_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fsm
//   Self-checking bench for uart_rx_fsm (CLKS_PER_BIT = 16). Expected frames
//   are queued when a frame is transmitted and compared when the receiver
//   hands them over on valid && ready.
// -----------------------------------------------------------------------------
module tb_uart_rx_fsm;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       rx = 1'b1;
  logic [1:0] num_data = 2'd3;
  logic       parity = 1'b0;
  logic       stop_2 = 1'b0;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun_err;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   spike_bit = -1;

  uart_rx_fsm #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .rx          (rx),
    .num_data    (num_data),
    .parity      (parity),
    .stop_2      (stop_2),
    .data        (data),
    .valid       (valid),
    .ready       (ready),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  // Scoreboard: every handshake must match the oldest queued frame.
  always @(negedge clk) begin
    exp_t e;
    if (arst_n && valid && ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got data=%h, expected no frame", data);
      end else begin
        e = exp_q.pop_front();
        n_cmp++;
        if (data !== e.data) begin
          n_bad++;
          $display("FAIL rx_data: got %h, expected %h", data, e.data);
        end
        n_cmp++;
        if (parity_err !== e.perr) begin
          n_bad++;
          $display("FAIL rx_parity_err (data %h): got %b, expected %b", e.data, parity_err, e.perr);
        end
        n_cmp++;
        if (frame_err !== e.ferr) begin
          n_bad++;
          $display("FAIL rx_frame_err (data %h): got %b, expected %b", e.data, frame_err, e.ferr);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  // Transmit one frame; optionally queue its expected receive result.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] nd,
                            input logic par, input logic par_flip,
                            input logic st2, input logic st2_val,
                            input logic expect_it);
    logic [7:0] m;
    m = d & (8'hFF >> (2'd3 - nd));
    num_data = nd;
    parity   = par;
    stop_2   = st2;
    if (expect_it)
      exp_q.push_back(exp_t'{data: m, perr: par & par_flip, ferr: st2 & ~st2_val});
    send_bit(1'b0);
    for (int i = 0; i < 5 + int'(nd); i++) begin
      if (i == spike_bit) begin
        rx = m[i];
        repeat (CPB / 2 - 1) @(negedge clk);
        rx = ~m[i];
        @(negedge clk);
        rx = m[i];
        repeat (CPB / 2) @(negedge clk);
      end else begin
        send_bit(m[i]);
      end
    end
    if (par) send_bit((^m) ^ par_flip);
    send_bit(1'b1);
    if (st2) send_bit(st2_val);
    rx = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s: %0d frames still pending, expected 0", name, exp_q.size());
    end
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({data, valid, parity_err, frame_err, overrun_err} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_outputs: got data=%h v=%b pe=%b fe=%b oe=%b, expected all 0",
               data, valid, parity_err, frame_err, overrun_err);
    end
    arst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    n_cmp++;
    if (valid !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: got valid=%b, expected 0", valid);
    end
  endtask

  task automatic test_8n1();
    send_frame(8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_drain("8n1_a5");
  endtask

  task automatic test_parity();
    send_frame(8'h15, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    wait_drain("5e1_bad_parity");
    send_frame(8'h6B, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    wait_drain("7e2_good_parity");
  endtask

  task automatic test_stop2();
    send_frame(8'h81, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    send_frame(8'h3C, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    wait_drain("8n2_stop_err");
  endtask

  task automatic test_false_start();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    n_cmp++;
    if (valid !== 1'b0) begin
      n_bad++;
      $display("FAIL false_start: got valid=%b, expected 0", valid);
    end
    send_frame(8'h5A, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_drain("after_false_start");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 5; k++) begin
      send_frame(8'($urandom), 2'($urandom), 1'($urandom), 1'b0,
                 1'($urandom), 1'b1, 1'b1);
    end
    wait_drain("back_to_back");
  endtask

  task automatic test_overrun();
    ready = 1'b0;
    send_frame(8'h11, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(8'h22, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    n_cmp++;
    if ({valid, data, overrun_err} !== {1'b1, 8'h11, 1'b1}) begin
      n_bad++;
      $display("FAIL overrun_hold: got v=%b data=%h oe=%b, expected v=1 data=11 oe=1",
               valid, data, overrun_err);
    end
    @(posedge clk); #1 ready = 1'b1;
    @(posedge clk); #1 ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({valid, data, overrun_err} !== {1'b0, 8'h11, 1'b0}) begin
      n_bad++;
      $display("FAIL overrun_accept: got v=%b data=%h oe=%b, expected v=0 data=11 oe=0",
               valid, data, overrun_err);
    end
    ready = 1'b1;
    wait_drain("overrun");
  endtask

  task automatic test_reset_mid_frame();
    num_data = 2'd3;
    parity   = 1'b0;
    stop_2   = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rx = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    arst_n = 1'b0;
    #1;
    n_cmp++;
    if ({data, valid, parity_err, frame_err, overrun_err} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_mid_frame: got data=%h v=%b pe=%b fe=%b oe=%b, expected all 0",
               data, valid, parity_err, frame_err, overrun_err);
    end
    repeat (4) @(negedge clk);
    arst_n = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    n_cmp++;
    if (valid !== 1'b0) begin
      n_bad++;
      $display("FAIL no_valid_after_abort: got valid=%b, expected 0", valid);
    end
    send_frame(8'hC3, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_drain("after_mid_reset");
  endtask

`ifdef UART_RX_GLITCH_FILTER_EN
  task automatic test_glitch();
    spike_bit = 2;
    send_frame(8'h00, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    spike_bit = 4;
    send_frame(8'hFF, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    spike_bit = -1;
    wait_drain("glitch_filter");
  endtask
`endif

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_stop2();
    test_false_start();
    test_back_to_back();
    test_overrun();
    test_reset_mid_frame();
`ifdef UART_RX_GLITCH_FILTER_EN
    test_glitch();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
